// File: rtl/mem_line_responder.sv
// Line-granular main-memory responder: one read/write at a time, fixed LATENCY, valid/ready response.
// Optional statistics counters are enabled by defining MEM_RESP_STATS_EN.
module mem_line_responder #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LINE_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [LINE_W-1:0] rsp_rdata
`ifdef MEM_RESP_STATS_EN
    ,
    output logic [31:0]       stat_reads,
    output logic [31:0]       stat_writes,
    output logic [31:0]       stat_busy
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               write_q, write_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LINE_W-1:0]  wdata_q, wdata_d;
    logic [LINE_W-1:0]  rdata_q, rdata_d;
    logic               ready_q;
    logic               accept;
    logic               commit;

    logic [LINE_W-1:0]  mem_q [DEPTH];

    logic unused_addr;
    assign unused_addr = ^{req_addr[ADDR_W-1:IDX_W+4], req_addr[3:0]};

    // ready_q keeps req_ready low until the first edge after reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= 1'b1;
        end
    end

    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        write_d   = write_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = ready_q;
                if (req_valid && ready_q) begin
                    accept  = 1'b1;
                    write_d = req_write;
                    idx_d   = req_addr[IDX_W+3:4];
                    wdata_d = req_wdata;
                    cnt_d   = 8'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 8'd0) begin
                    commit  = 1'b1;
                    rdata_d = write_q ? wdata_q : mem_q[idx_q];
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the line array is deliberately not reset; contents stay undefined until written.
    always_ff @(posedge clk) begin
        if (commit && write_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign rsp_rdata = rdata_q;

`ifdef MEM_RESP_STATS_EN
    logic [31:0] reads_q, writes_q, busy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reads_q  <= '0;
            writes_q <= '0;
            busy_q   <= '0;
        end else begin
            if (accept && !req_write && reads_q != '1) begin
                reads_q <= reads_q + 32'd1;
            end
            if (accept && req_write && writes_q != '1) begin
                writes_q <= writes_q + 32'd1;
            end
            if (state_q != IDLE && busy_q != '1) begin
                busy_q <= busy_q + 32'd1;
            end
        end
    end

    assign stat_reads  = reads_q;
    assign stat_writes = writes_q;
    assign stat_busy   = busy_q;
`endif

endmodule

// File: tb/tb_mem_line_responder.sv
// Scoreboard bench for mem_line_responder: stimulus pushes expected lines, a monitor pops on each handshake.
// Statistics checks are compiled in when MEM_RESP_STATS_EN is defined.
module tb_mem_line_responder;

    localparam logic [127:0] L0   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] LA   = 128'hA5A5A5A5_0F0F0F0F_12345678_9ABCDEF0;
    localparam logic [127:0] LB   = 128'hDEADBEEF_CAFEF00D_01020304_05060708;
    localparam logic [127:0] LC   = 128'h13579BDF_2468ACE0_FEDCBA98_76543210;
    localparam logic [127:0] ONES = {128{1'b1}};

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [31:0]  req_addr;
    logic [127:0] req_wdata;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_rdata;
`ifdef MEM_RESP_STATS_EN
    logic [31:0]  stat_reads, stat_writes, stat_busy;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [127:0] exp_q [$];

    mem_line_responder dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata)
`ifdef MEM_RESP_STATS_EN
        ,
        .stat_reads  (stat_reads),
        .stat_writes (stat_writes),
        .stat_busy   (stat_busy)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted response is compared against the oldest expected line.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_response", 128'd1, 128'd0);
            end else begin
                check("rsp_rdata", rsp_rdata, exp_q.pop_front());
            end
        end
    end

    // Presents a request until accepted; acc returns the cycle count just after the accepting edge.
    task automatic send(input logic wr, input logic [31:0] addr, input logic [127:0] data,
                        input logic [127:0] exp, input bit push, output int acc);
        int  n   = 0;
        bit  rdy;
        acc       = -1;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = data;
        while (acc < 0 && n < 100) begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            #1;
            n++;
            if (rdy) begin
                acc = cyc;
                if (push) exp_q.push_back(exp);
            end
        end
        check("accepted_in_time", 128'(acc >= 0), 128'd1);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int seen);
        int n   = 0;
        bit got = 1'b0;
        seen = -1;
        while (!got && n < 300) begin
            @(negedge clk);
            n++;
            if (rsp_valid) begin
                got  = 1'b1;
                seen = cyc;
            end
        end
        check("rsp_in_time", 128'(got), 128'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, seen, hs;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;

        #12;
        check("reset_req_ready", 128'(req_ready), 128'd0);
        check("reset_rsp_valid", 128'(rsp_valid), 128'd0);
        check("reset_rsp_rdata", rsp_rdata, 128'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("ready_before_first_edge", 128'(req_ready), 128'd0);
        @(posedge clk);
        #1;
        check("ready_after_first_edge", 128'(req_ready), 128'd1);

        // Write then read with latency measurement
        rsp_ready = 1'b1;
        send(1'b1, 32'h40, L0, L0, 1'b1, acc);
        wait_rsp(seen);
        send(1'b0, 32'h40, '0, L0, 1'b1, acc);
        wait_rsp(seen);
        check("read_latency", 128'(seen - acc), 128'd5);

        // Aliasing: offset bits and bits above the index are ignored
        send(1'b1, 32'h0000_0010, LA, LA, 1'b1, acc);
        wait_rsp(seen);
        send(1'b0, 32'h0000_1010, '0, LA, 1'b1, acc);
        wait_rsp(seen);
        send(1'b0, 32'h0000_001C, '0, LA, 1'b1, acc);
        wait_rsp(seen);

        // Backpressure with a pending request
        rsp_ready = 1'b0;
        send(1'b0, 32'h40, '0, L0, 1'b1, acc);
        wait_rsp(seen);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_1010;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 128'(rsp_valid), 128'd1);
            check("bp_rsp_rdata", rsp_rdata, L0);
            check("bp_req_ready", 128'(req_ready), 128'd0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("hs_req_ready", 128'(req_ready), 128'd0);
        @(posedge clk);
        #1;
        hs = cyc;
        send(1'b0, 32'h0000_1010, '0, LA, 1'b1, acc);
        check("accept_after_handshake", 128'(acc - hs), 128'd1);
        wait_rsp(seen);

        // Back-to-back reads
        send(1'b0, 32'h10, '0, LA, 1'b1, acc);
        send(1'b0, 32'h40, '0, L0, 1'b1, acc2);
        check("back_to_back_spacing", 128'(acc2 - acc), 128'd7);
        wait_rsp(seen);

        // Reset during a pending write: the write must be lost
        send(1'b1, 32'h80, '0, '0, 1'b1, acc);
        wait_rsp(seen);
        send(1'b1, 32'h80, ONES, ONES, 1'b0, acc);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_rsp_valid", 128'(rsp_valid), 128'd0);
        check("midrst_req_ready", 128'(req_ready), 128'd0);
        check("midrst_rsp_rdata", rsp_rdata, 128'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Three reads and two writes, each drained as soon as valid
        send(1'b0, 32'h80, '0, 128'd0, 1'b1, acc);
        wait_rsp(seen);
        send(1'b0, 32'h40, '0, L0, 1'b1, acc);
        wait_rsp(seen);
        send(1'b0, 32'h1C, '0, LA, 1'b1, acc);
        wait_rsp(seen);
        send(1'b1, 32'hC0, LB, LB, 1'b1, acc);
        wait_rsp(seen);
        send(1'b1, 32'h1C0, LC, LC, 1'b1, acc);
        wait_rsp(seen);
`ifdef MEM_RESP_STATS_EN
        check("stat_reads", 128'(stat_reads), 128'd3);
        check("stat_writes", 128'(stat_writes), 128'd2);
        check("stat_busy", 128'(stat_busy), 128'd30);
`endif
        send(1'b0, 32'hC0, '0, LB, 1'b1, acc);
        wait_rsp(seen);
        send(1'b0, 32'h1C0, '0, LC, 1'b1, acc);
        wait_rsp(seen);

        check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
